data_ram_ctrl: RTL
==================

// Module: data_ram_ctrl
// PURPOSE
//  Clocked, parametrised byte-addressable data memory for the MIPS datapath, driven by the MOV/MOC handshake.
//  Executes lb/lbu/lh/lhu/lw/ld reads and sb/sh/sw/sd writes with a programmable access latency.
//  ld and sd are two-beat 64-bit transfers; the block latches their address on beat 1.
//  Misaligned accesses and unsupported opcodes are reported on op_err instead of being silently masked.
// PARAMETERS
//  ADDR_W   9  byte-address width; memory depth is 2**ADDR_W bytes
//  LATENCY  3  clk cycles from request accept to moc; legal range 1..15
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       synchronous, active-high
//  mov         in   1       memory operation valid (level)
//  read_write  in   1       1 = read, 0 = write
//  opcode      in   6       MIPS load/store opcode
//  address     in   ADDR_W  byte address; big-endian (MSB byte at lowest address)
//  data_in     in   32      store data
//  data_out    out  32      load data; valid while moc=1 and held until the next completed read
//  moc         out  1       memory operation complete
//  dmoc        out  1       1 = ld/sd beat 1 is done and beat 2 is pending
//  op_err      out  1       request rejected (misaligned or unsupported); valid with moc
// BEHAVIOUR
//  Reset values: data_out=0, moc=0, dmoc=0, op_err=0, FSM=IDLE. Memory array is not cleared.
//  Reset mid-operation: any pending write is dropped. The beat counter clears.
//  Opcodes:
//   ld=110101, lw=100011, lhu=100101, lh=100001, lbu=100100, lb=100000
//   sd=111111, sw=101011, sh=101001, sb=101000
//  FSM states: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: if mov=1 at a clk edge, latch read_write, opcode, address and data_in, then go to WAIT. cnt = LATENCY-1.
//   WAIT: cnt decrements every cycle. When cnt=0, perform the access and go to DONE.
//         The input latch makes mov/address changes during WAIT irrelevant.
//   DONE: moc=1. Hold DONE until mov=0, then go to IDLE with moc=0 on the next cycle.
//         A mov that stays high never re-triggers a request.
//  Latency: moc=1 in the cycle LATENCY edges after the accept edge. With LATENCY=1, moc rises one edge after accept.
//  Reads (data_out updates on the DONE-entry edge):
//   lb/lh: sign-extend to 32 bits. lbu/lhu: zero-extend.
//   lw: {M[a],M[a+1],M[a+2],M[a+3]}.
//  Writes: bytes are written on the DONE-entry edge. data_out is unchanged.
//  Alignment: required alignment is h=2, w=4, d=8 bytes.
//   A misaligned request completes normally with op_err=1.
//   It makes no memory change, leaves data_out unchanged and does not change dmoc.
//  Unsupported opcode: same response as misaligned (op_err=1, no side effects).
//  op_err is cleared on the next accept.
//  Doubleword (ld/sd):
//   Beat 1 uses bytes a..a+3 (a = 8-aligned address latched at beat 1). On completion dmoc=1.
//   Beat 2 is the next request with the same opcode while dmoc=1. It uses a+4..a+7 and ignores the new address.
//   On beat 2 completion dmoc=0.
//   If dmoc=1 and a different opcode is accepted: dmoc clears and the new request executes as a fresh operation.
//  Address arithmetic: because of the alignment rules, a+k never wraps within a legal access.
//   Indices are taken modulo 2**ADDR_W.
//  Simultaneous reset and mov: reset wins. The request is not accepted.
// TESTING
//  1. sw 0xDEADBEEF @0x010, then lw @0x010 (LATENCY=3):
//     moc rises 3 cycles after accept; data_out=0xDEADBEEF.
//  2. sb 0x80 @0x021, then lb @0x021 -> 0xFFFFFF80; lbu @0x021 -> 0x00000080;
//     lh @0x020 (M[0x20]=0x00) -> 0x00000080.
//  3. sd beats 0x11223344 then 0x55667788 @0x040 (beat-2 address driven 0x1FF):
//     dmoc goes 1 then 0.
//     ld @0x040 returns 0x11223344 then 0x55667788.
//  4. sw @0x012 -> moc=1, op_err=1, memory unchanged (lw @0x010 returns the previous value).
//     Opcode 000000 -> op_err=1.
//  5. Hold mov=1 for 10 cycles after moc -> exactly one access, moc stays 1.
//     Drop mov -> moc=0 one cycle later.
//  6. Assert reset during WAIT of sw @0x030 -> moc=0, M[0x30..0x33] unchanged.
//     ld beat 1 then lw -> dmoc clears, lw executes normally.

Source files
------------

// File: rtl/data_ram_ctrl_if.sv
// Request/response bundle between the MIPS datapath and the data RAM controller.
// The datapath holds the master side; the controller holds the slave side.
interface data_ram_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              mov;
    logic              read_write;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              moc;
    logic              dmoc;
    logic              op_err;

    modport master (
        output mov, read_write, opcode, address, data_in,
        input  data_out, moc, dmoc, op_err
    );

    modport slave (
        input  mov, read_write, opcode, address, data_in,
        output data_out, moc, dmoc, op_err
    );
endinterface

// File: rtl/data_ram_ctrl.sv
// Byte-addressable big-endian data memory with MOV/MOC handshake, programmable
// latency, two-beat ld/sd transfers and error reporting for bad requests.
module data_ram_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int LATENCY = 3
) (
    input logic            clk,
    input logic            reset,
    data_ram_ctrl_if.slave bus
);
    localparam logic [5:0] OP_LD  = 6'b110101, OP_LW = 6'b100011, OP_LHU = 6'b100101,
                           OP_LH  = 6'b100001, OP_LBU = 6'b100100, OP_LB = 6'b100000,
                           OP_SD  = 6'b111111, OP_SW = 6'b101011, OP_SH = 6'b101001,
                           OP_SB  = 6'b101000;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic              accept, access;
    logic [3:0]        cnt;
    logic              rw_q, beat2_q;
    logic [5:0]        op_q;
    logic [ADDR_W-1:0] addr_q, base_q;
    logic [31:0]       din_q, data_q;
    logic              dmoc_q, err_q;
    logic [7:0]        mem [2**ADDR_W];

    logic              is_dbl, is_load, is_store, misaligned, err;
    logic [ADDR_W-1:0] ea, ea1, ea2, ea3;
    logic [31:0]       rdata;

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            IDLE: if (bus.mov) begin
                accept   = 1'b1;
                state_nx = WAIT;
            end
            WAIT: if (cnt == '0) begin
                access   = 1'b1;
                state_nx = DONE;
            end
            DONE: if (!bus.mov) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Opcode direction must agree with read_write, otherwise the request is unsupported.
    always_comb begin
        is_dbl   = (op_q == OP_LD) || (op_q == OP_SD);
        is_load  = op_q inside {OP_LD, OP_LW, OP_LHU, OP_LH, OP_LBU, OP_LB};
        is_store = op_q inside {OP_SD, OP_SW, OP_SH, OP_SB};
        case (op_q)
            OP_LH, OP_LHU, OP_SH: misaligned = addr_q[0];
            OP_LW, OP_SW:         misaligned = |addr_q[1:0];
            OP_LD, OP_SD:         misaligned = !beat2_q && (|addr_q[2:0]);
            default:              misaligned = 1'b0;
        endcase
        err = !(rw_q ? is_load : is_store) || misaligned;
        // Beat 2 ignores the request address and continues from the beat-1 base.
        ea  = beat2_q ? base_q + ADDR_W'(4) : addr_q;
        ea1 = ea + ADDR_W'(1);
        ea2 = ea + ADDR_W'(2);
        ea3 = ea + ADDR_W'(3);
        case (op_q)
            OP_LB:   rdata = {{24{mem[ea][7]}}, mem[ea]};
            OP_LBU:  rdata = {24'd0, mem[ea]};
            OP_LH:   rdata = {{16{mem[ea][7]}}, mem[ea], mem[ea1]};
            OP_LHU:  rdata = {16'd0, mem[ea], mem[ea1]};
            default: rdata = {mem[ea], mem[ea1], mem[ea2], mem[ea3]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            beat2_q <= 1'b0;
            dmoc_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                rw_q    <= bus.read_write;
                op_q    <= bus.opcode;
                addr_q  <= bus.address;
                din_q   <= bus.data_in;
                cnt     <= 4'(LATENCY - 1);
                err_q   <= 1'b0;
                beat2_q <= dmoc_q && (bus.opcode == op_q);
                // A different opcode abandons the pending second beat.
                if (dmoc_q && bus.opcode != op_q) dmoc_q <= 1'b0;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                err_q <= err;
                if (!err) begin
                    if (rw_q) data_q <= rdata;
                    if (is_dbl) begin
                        dmoc_q <= !beat2_q;
                        if (!beat2_q) base_q <= addr_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && access && !rw_q && !err) begin
            case (op_q)
                OP_SB: mem[ea] <= din_q[7:0];
                OP_SH: begin
                    mem[ea]  <= din_q[15:8];
                    mem[ea1] <= din_q[7:0];
                end
                default: begin
                    mem[ea]  <= din_q[31:24];
                    mem[ea1] <= din_q[23:16];
                    mem[ea2] <= din_q[15:8];
                    mem[ea3] <= din_q[7:0];
                end
            endcase
        end
    end

    assign bus.moc      = (state == DONE);
    assign bus.dmoc     = dmoc_q;
    assign bus.op_err   = err_q;
    assign bus.data_out = data_q;
endmodule
